// File: rtl/bcd_pkg.sv
// Shared constants and digit types for the BCD 8421 to Excess-3 converter.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;
  typedef logic [3:0] ex3_digit_t;

  localparam bcd_digit_t EX3_OFFSET  = 4'd3;
  localparam bcd_digit_t BCD_MAX     = 4'd9;
  // 0000 never occurs as a legal Excess-3 code, so it marks a bad input digit.
  localparam ex3_digit_t EX3_INVALID = 4'b0000;

endpackage

// File: rtl/bcd_digit_to_ex3.sv
// Combinational single-digit BCD 8421 -> Excess-3 converter with illegal-code flag.
module bcd_digit_to_ex3
  import bcd_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [3:0] ex3_o,
  output logic       err_o
);

  always_comb begin
    err_o = (bcd_i > BCD_MAX);
    ex3_o = bcd_i + EX3_OFFSET;
    if (err_o) begin
      ex3_o = EX3_INVALID;
    end
  end

endmodule

// File: rtl/bcd8421_to_excess3.sv
// One-cycle registered multi-digit BCD 8421 -> Excess-3 stage with valid and per-digit error flags.
module bcd8421_to_excess3
  import bcd_pkg::*;
#(
  parameter int DIGITS = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic [4*DIGITS-1:0]   ex3_out,
  output logic                  out_valid,
  output logic [DIGITS-1:0]     digit_err,
  output logic                  any_err
);

  logic [4*DIGITS-1:0] conv_word;
  logic [DIGITS-1:0]   conv_err;

  logic [4*DIGITS-1:0] ex3_q, ex3_d;
  logic [DIGITS-1:0]   digit_err_q, digit_err_d;
  logic                any_err_q, any_err_d;
  logic                out_valid_q, out_valid_d;

  // Digits are independent: no carry crosses a digit boundary.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_digit_to_ex3 u_digit (
        .bcd_i (bcd_in[4*gi +: 4]),
        .ex3_o (conv_word[4*gi +: 4]),
        .err_o (conv_err[gi])
      );
    end
  endgenerate

  // Data and error flags hold across invalid cycles; only out_valid drops.
  always_comb begin
    ex3_d       = ex3_q;
    digit_err_d = digit_err_q;
    any_err_d   = any_err_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      ex3_d       = conv_word;
      digit_err_d = conv_err;
      any_err_d   = |conv_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex3_q       <= '0;
      digit_err_q <= '0;
      any_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      ex3_q       <= ex3_d;
      digit_err_q <= digit_err_d;
      any_err_q   <= any_err_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign ex3_out   = ex3_q;
  assign digit_err = digit_err_q;
  assign any_err   = any_err_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_bcd8421_to_excess3.sv
// Self-checking bench: a 1-digit and a 4-digit converter driven in lockstep against a digit-arithmetic model.
module tb_bcd8421_to_excess3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  bcd1 = '0;
  logic [15:0] bcd4 = '0;

  logic [3:0]  ex1;
  logic        ov1;
  logic [0:0]  de1;
  logic        ae1;
  logic [15:0] ex4;
  logic        ov4;
  logic [3:0]  de4;
  logic        ae4;

  int tests_run = 0;
  int tests_failed = 0;

  // Model state: what the outputs should currently show.
  logic [63:0] m_ex1, m_ex4;
  logic [15:0] m_de1, m_de4;
  logic        m_valid;

  always #5 clk = ~clk;

  bcd8421_to_excess3 #(.DIGITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .bcd_in(bcd1),
    .ex3_out(ex1), .out_valid(ov1), .digit_err(de1), .any_err(ae1)
  );

  bcd8421_to_excess3 #(.DIGITS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .bcd_in(bcd4),
    .ex3_out(ex4), .out_valid(ov4), .digit_err(de4), .any_err(ae4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: each decimal digit d becomes d+3; anything above 9 becomes 0 and is flagged.
  function automatic void ref_conv(input logic [63:0] w, input int n,
                                   output logic [63:0] ex, output logic [15:0] er);
    ex = '0;
    er = '0;
    for (int k = 0; k < n; k++) begin
      int d;
      d = int'((w >> (4 * k)) & 64'hF);
      if (d > 9) er[k] = 1'b1;
      else ex = ex | (64'(d + 3) << (4 * k));
    end
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".ov1"}, 64'(ov1), 64'(m_valid));
    check({tag, ".ex1"}, 64'(ex1), m_ex1);
    check({tag, ".de1"}, 64'(de1), 64'(m_de1));
    check({tag, ".ae1"}, 64'(ae1), 64'(|m_de1));
    check({tag, ".ov4"}, 64'(ov4), 64'(m_valid));
    check({tag, ".ex4"}, 64'(ex4), m_ex4);
    check({tag, ".de4"}, 64'(de4), 64'(m_de4));
    check({tag, ".ae4"}, 64'(ae4), 64'(|m_de4));
  endtask

  task automatic step(input string tag, input logic v, input logic [3:0] w1, input logic [15:0] w4);
    @(negedge clk);
    in_valid = v;
    bcd1 = w1;
    bcd4 = w4;
    @(posedge clk);
    #1;
    if (v) begin
      ref_conv(64'(w1), 1, m_ex1, m_de1);
      ref_conv(64'(w4), 4, m_ex4, m_de4);
    end
    m_valid = v;
    compare_all(tag);
    $display("[TB] %s v=%0b in1=%h in4=%h -> ex1=%h ov=%0b ex4=%h de4=%b", tag, v, w1, w4, ex1, ov1, ex4, de4);
  endtask

  task automatic model_reset();
    m_ex1 = '0; m_ex4 = '0; m_de1 = '0; m_de4 = '0; m_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    #12;
    compare_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single samples and boundary digits.
    step("zero", 1'b1, 4'h0, 16'h0000);
    check("zero.const", 64'(ex1), 64'h3);
    step("nine", 1'b1, 4'h9, 16'h9999);
    check("nine.const", 64'(ex1), 64'hC);

    // Back-to-back sweep 0..9.
    for (int i = 0; i < 10; i++) begin
      step("sweep", 1'b1, 4'(i), {4'(9 - i), 4'(i), 4'(9 - i), 4'(i)});
      check("sweep.const", 64'(ex1), 64'(i + 3));
    end

    // Illegal codes then recovery.
    step("ill_a", 1'b1, 4'hA, 16'hA000);
    check("ill_a.const", 64'({ex1, ae1}), 64'h1);
    step("ill_f", 1'b1, 4'hF, 16'h0F0F);
    step("recover", 1'b1, 4'h5, 16'h5555);
    check("recover.const", 64'({ex1, ae1}), 64'h10);

    // Packed words.
    step("w1234", 1'b1, 4'h4, 16'h1234);
    check("w1234.const", 64'(ex4), 64'h4567);
    step("w9a05", 1'b1, 4'h5, 16'h9A05);
    check("w9a05.const", 64'({ex4, de4, ae4}), 64'({16'hC038, 4'b0100, 1'b1}));

    // Valid gap: data holds, out_valid drops.
    step("pre_gap", 1'b1, 4'h3, 16'h3333);
    step("gap1", 1'b0, 4'h8, 16'h8888);
    step("gap2", 1'b0, 4'hB, 16'hBBBB);
    check("gap.hold", 64'({ex1, ov1}), 64'({4'h6, 1'b0}));

    // Asynchronous reset between edges while out_valid is high.
    step("pre_rst", 1'b1, 4'h2, 16'h2468);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", 1'b1, 4'h7, 16'h7007);
    check("post_rst.const", 64'({ex1, ov1}), 64'({4'hA, 1'b1}));

    // Randomized stream.
    for (int i = 0; i < 200; i++) begin
      logic v;
      logic [3:0] w1;
      logic [15:0] w4;
      v  = ($urandom_range(0, 3) != 0);
      w1 = 4'($urandom_range(0, 15));
      w4 = 16'($urandom() & 32'hFFFF);
      step("rand", v, w1, w4);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
